// File: rtl/pipe_regs_de_em_pkg.sv
// Shared widths, bubble encoding and stage payload layouts for the D/E and E/M pipeline registers.
package pipe_regs_de_em_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned TNEW_W = 2;

    localparam logic [DATA_W-1:0] BUBBLE_INSTR = 32'h0;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] ext;
        logic [REG_AW-1:0] a3;
        logic [TNEW_W-1:0] tnew;
        logic              valid;
    } de_bus_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] rd2;
        logic [REG_AW-1:0] a3;
        logic [TNEW_W-1:0] tnew;
        logic              valid;
    } em_bus_t;

    // One stage older: Tnew drops by one but never wraps below zero.
    function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] tnew);
        return (tnew == '0) ? '0 : TNEW_W'(tnew - TNEW_W'(1));
    endfunction

endpackage

// File: rtl/pipe_regs_de_em_stage_reg.sv
// Generic stage_reg: a registered field bundle with async reset to zero and synchronous clear.
module pipe_regs_de_em_stage_reg #(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = d;
        if (clear) begin
            data_d = CLR_VAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_regs_de_em.sv
// D->E and E->M pipeline registers of the 5-stage MIPS pipe, with bubble insertion,
// Tnew aging and a saturating bubble counter.
module pipe_regs_de_em
    import pipe_regs_de_em_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flushEX,
    input  logic [DATA_W-1:0] PC_D,
    input  logic [DATA_W-1:0] Instr_D,
    input  logic [DATA_W-1:0] RD1_D,
    input  logic [DATA_W-1:0] RD2_D,
    input  logic [DATA_W-1:0] Ext_D,
    input  logic [REG_AW-1:0] A3_D,
    input  logic [TNEW_W-1:0] Tnew_D,
    output logic [DATA_W-1:0] PC_E,
    output logic [DATA_W-1:0] Instr_E,
    output logic [DATA_W-1:0] RD1_E,
    output logic [DATA_W-1:0] RD2_E,
    output logic [DATA_W-1:0] Ext_E,
    output logic [REG_AW-1:0] A3_E,
    output logic [TNEW_W-1:0] Tnew_E,
    output logic              valid_E,
    input  logic [DATA_W-1:0] ALUOut_E,
    input  logic [DATA_W-1:0] RD2fwd_E,
    output logic [DATA_W-1:0] PC_M,
    output logic [DATA_W-1:0] Instr_M,
    output logic [DATA_W-1:0] ALUOut_M,
    output logic [DATA_W-1:0] RD2_M,
    output logic [REG_AW-1:0] A3_M,
    output logic [TNEW_W-1:0] Tnew_M,
    output logic              valid_M,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned DE_W = $bits(de_bus_t);
    localparam int unsigned EM_W = $bits(em_bus_t);

    localparam de_bus_t DE_BUBBLE = '{
        pc:    '0,
        instr: BUBBLE_INSTR,
        rd1:   '0,
        rd2:   '0,
        ext:   '0,
        a3:    '0,
        tnew:  '0,
        valid: 1'b0
    };

    de_bus_t          de_d;
    de_bus_t          de_q;
    em_bus_t          em_d;
    em_bus_t          em_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;

    // A write to $0 never creates a dependency, so its Tnew is dropped on entry.
    always_comb begin
        de_d.pc    = PC_D;
        de_d.instr = Instr_D;
        de_d.rd1   = RD1_D;
        de_d.rd2   = RD2_D;
        de_d.ext   = Ext_D;
        de_d.a3    = A3_D;
        de_d.tnew  = (A3_D == '0) ? '0 : Tnew_D;
        de_d.valid = 1'b1;
    end

    pipe_regs_de_em_stage_reg #(
        .W       (DE_W),
        .CLR_VAL (DE_BUBBLE)
    ) u_de_reg (
        .clk   (clk),
        .reset (reset),
        .clear (flushEX),
        .d     (de_d),
        .q     (de_q)
    );

    always_comb begin
        em_d.pc      = de_q.pc;
        em_d.instr   = de_q.instr;
        em_d.alu_out = ALUOut_E;
        em_d.rd2     = RD2fwd_E;
        em_d.a3      = de_q.a3;
        em_d.tnew    = tnew_age(de_q.tnew);
        em_d.valid   = de_q.valid;
    end

    pipe_regs_de_em_stage_reg #(
        .W       (EM_W),
        .CLR_VAL ('0)
    ) u_em_reg (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .d     (em_d),
        .q     (em_q)
    );

    // Saturating count of bubbles inserted into E.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (flushEX && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = CNT_W'(bubble_cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign PC_E       = de_q.pc;
    assign Instr_E    = de_q.instr;
    assign RD1_E      = de_q.rd1;
    assign RD2_E      = de_q.rd2;
    assign Ext_E      = de_q.ext;
    assign A3_E       = de_q.a3;
    assign Tnew_E     = de_q.tnew;
    assign valid_E    = de_q.valid;

    assign PC_M       = em_q.pc;
    assign Instr_M    = em_q.instr;
    assign ALUOut_M   = em_q.alu_out;
    assign RD2_M      = em_q.rd2;
    assign A3_M       = em_q.a3;
    assign Tnew_M     = em_q.tnew;
    assign valid_M    = em_q.valid;

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_regs_de_em.sv
// Directed bench for pipe_regs_de_em: flow, flush, Tnew aging, $0 handling, reset and counter saturation.
module tb_pipe_regs_de_em;

    localparam int unsigned CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flushEX;
    logic [31:0] PC_D, Instr_D, RD1_D, RD2_D, Ext_D;
    logic [4:0]  A3_D;
    logic [1:0]  Tnew_D;
    logic [31:0] PC_E, Instr_E, RD1_E, RD2_E, Ext_E;
    logic [4:0]  A3_E;
    logic [1:0]  Tnew_E;
    logic        valid_E;
    logic [31:0] ALUOut_E, RD2fwd_E;
    logic [31:0] PC_M, Instr_M, ALUOut_M, RD2_M;
    logic [4:0]  A3_M;
    logic [1:0]  Tnew_M;
    logic        valid_M;
    logic [CNT_W-1:0] bubble_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    pipe_regs_de_em #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flushEX(flushEX),
        .PC_D(PC_D), .Instr_D(Instr_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .Ext_D(Ext_D),
        .A3_D(A3_D), .Tnew_D(Tnew_D),
        .PC_E(PC_E), .Instr_E(Instr_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .Ext_E(Ext_E),
        .A3_E(A3_E), .Tnew_E(Tnew_E), .valid_E(valid_E),
        .ALUOut_E(ALUOut_E), .RD2fwd_E(RD2fwd_E),
        .PC_M(PC_M), .Instr_M(Instr_M), .ALUOut_M(ALUOut_M), .RD2_M(RD2_M),
        .A3_M(A3_M), .Tnew_M(Tnew_M), .valid_M(valid_M),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [4:0] a3, input logic [1:0] tnew);
        PC_D    = pc;
        Instr_D = instr;
        A3_D    = a3;
        Tnew_D  = tnew;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".PC_E"},    PC_E, 32'h0);
        chk({tag, ".Instr_E"}, Instr_E, 32'h0);
        chk({tag, ".RD1_E"},   RD1_E, 32'h0);
        chk({tag, ".Tnew_E"},  32'(Tnew_E), 32'h0);
        chk({tag, ".valid_E"}, 32'(valid_E), 32'h0);
        chk({tag, ".PC_M"},    PC_M, 32'h0);
        chk({tag, ".ALUOut_M"}, ALUOut_M, 32'h0);
        chk({tag, ".A3_M"},    32'(A3_M), 32'h0);
        chk({tag, ".Tnew_M"},  32'(Tnew_M), 32'h0);
        chk({tag, ".valid_M"}, 32'(valid_M), 32'h0);
        chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        flushEX  = 1'b0;
        RD1_D    = 32'h11;
        RD2_D    = 32'h22;
        Ext_D    = 32'h5;
        ALUOut_E = 32'h0;
        RD2fwd_E = 32'h0;
        drive_d(32'h0, 32'h0, 5'd0, 2'd0);
        #2;
        chk_all_zero("por");
        step();
        step();
        reset = 1'b0;

        // ori $1,$0,5
        drive_d(32'h3000, 32'h3401_0005, 5'd1, 2'd1);
        step();
        chk("flow.PC_E", PC_E, 32'h3000);
        chk("flow.Instr_E", Instr_E, 32'h3401_0005);
        chk("flow.RD1_E", RD1_E, 32'h11);
        chk("flow.RD2_E", RD2_E, 32'h22);
        chk("flow.Ext_E", Ext_E, 32'h5);
        chk("flow.A3_E", 32'(A3_E), 32'd1);
        chk("flow.Tnew_E", 32'(Tnew_E), 32'd1);
        chk("flow.valid_E", 32'(valid_E), 32'd1);

        // Flush while ori moves to M
        ALUOut_E = 32'h5;
        RD2fwd_E = 32'h22;
        flushEX  = 1'b1;
        drive_d(32'h3004, 32'hDEAD_BEEF, 5'd3, 2'd2);
        step();
        chk("flush.Instr_E", Instr_E, 32'h0);
        chk("flush.PC_E", PC_E, 32'h0);
        chk("flush.RD1_E", RD1_E, 32'h0);
        chk("flush.A3_E", 32'(A3_E), 32'd0);
        chk("flush.Tnew_E", 32'(Tnew_E), 32'd0);
        chk("flush.valid_E", 32'(valid_E), 32'd0);
        chk("flush.bubble_cnt", 32'(bubble_cnt), 32'd1);
        chk("flow.PC_M", PC_M, 32'h3000);
        chk("flow.Instr_M", Instr_M, 32'h3401_0005);
        chk("flow.ALUOut_M", ALUOut_M, 32'h5);
        chk("flow.RD2_M", RD2_M, 32'h22);
        chk("flow.A3_M", 32'(A3_M), 32'd1);
        chk("flow.Tnew_M", 32'(Tnew_M), 32'd0);
        chk("flow.valid_M", 32'(valid_M), 32'd1);

        // lw $4 enters E, bubble reaches M
        flushEX  = 1'b0;
        ALUOut_E = 32'h77;
        drive_d(32'h3008, 32'h8C04_0000, 5'd4, 2'd2);
        step();
        chk("lw.Tnew_E", 32'(Tnew_E), 32'd2);
        chk("lw.A3_E", 32'(A3_E), 32'd4);
        chk("lw.valid_E", 32'(valid_E), 32'd1);
        chk("bub.valid_M", 32'(valid_M), 32'd0);
        chk("bub.A3_M", 32'(A3_M), 32'd0);
        chk("bub.PC_M", PC_M, 32'h0);
        chk("bub.bubble_cnt", 32'(bubble_cnt), 32'd1);

        // Tnew_D=0 follower; lw ages 2->1 in M
        drive_d(32'h300C, 32'h0000_2821, 5'd5, 2'd0);
        step();
        chk("lw.Tnew_M", 32'(Tnew_M), 32'd1);
        chk("lw.A3_M", 32'(A3_M), 32'd4);
        chk("t0.Tnew_E", 32'(Tnew_E), 32'd0);

        // $0 destination; Tnew 0 saturates in M
        drive_d(32'h3010, 32'h3400_0007, 5'd0, 2'd2);
        step();
        chk("zero.Tnew_E", 32'(Tnew_E), 32'd0);
        chk("zero.valid_E", 32'(valid_E), 32'd1);
        chk("zero.A3_E", 32'(A3_E), 32'd0);
        chk("t0.Tnew_M", 32'(Tnew_M), 32'd0);
        chk("t0.A3_M", 32'(A3_M), 32'd5);

        // Tnew 3 ages to 2
        drive_d(32'h3014, 32'h1234_5678, 5'd6, 2'd3);
        step();
        chk("t3.Tnew_E", 32'(Tnew_E), 32'd3);
        drive_d(32'h3018, 32'h0000_0000, 5'd7, 2'd1);
        step();
        chk("t3.Tnew_M", 32'(Tnew_M), 32'd2);
        chk("t3.A3_M", 32'(A3_M), 32'd6);

        // Mid-cycle asynchronous reset with nonzero registers
        reset = 1'b1;
        #1;
        chk_all_zero("arst");
        #2;
        reset = 1'b0;
        #1;
        chk("arst_rel.PC_E", PC_E, 32'h0);
        chk("arst_rel.valid_E", 32'(valid_E), 32'd0);
        step();
        chk("arst_cap.PC_E", PC_E, 32'h3018);
        chk("arst_cap.A3_E", 32'(A3_E), 32'd7);
        chk("arst_cap.valid_E", 32'(valid_E), 32'd1);
        chk("arst_cap.bubble_cnt", 32'(bubble_cnt), 32'd0);

        // Counter saturation at 15
        flushEX = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) chk("sat.cnt14", 32'(bubble_cnt), 32'd14);
        end
        chk("sat.cnt", 32'(bubble_cnt), 32'd15);
        chk("sat.valid_E", 32'(valid_E), 32'd0);

        // Reset together with flushEX: no increment
        reset = 1'b1;
        step();
        chk("rst_flush.cnt", 32'(bubble_cnt), 32'd0);
        reset   = 1'b0;
        flushEX = 1'b0;
        step();
        chk("rst_flush.cnt_after", 32'(bubble_cnt), 32'd0);
        chk("rst_flush.valid_E", 32'(valid_E), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
